cio_scheduler: RTL and testbench
================================

# cio_scheduler

Character-I/O scheduler between the DekatronPC core's console handshake (Cout / CinReq / CioAcq) and the emulator's I/O resources. Every output character goes to all enabled sinks, for example the display block and the host link, and the core is acknowledged only once every enabled sink has accepted it. Input characters from the keyboard and the host are arbitrated round-robin into a small FIFO and delivered on CinReq. It replaces the ad-hoc OR of per-consumer acknowledges at the emulator top level.

## Interface
Parameters:
- FIFO_DEPTH, 4: input FIFO entries, power of two, ≥2.
- SINKS, 2: number of output sinks.
- TIMEOUT_CYCLES, 4096: maximum cycles a broadcast waits for sinks; range 2..65535.

Ports:
- Clk  in  1  single clock.
- Rst  in  1  synchronous, active-high reset.
- Cout  in  1  core output request; level, held until CioAcq.
- CinReq  in  1  core input request; level, held until CioAcq.
- stdout  in  8  core output byte; valid while Cout is high.
- stdin  out  8  input byte to the core; valid in the CioAcq cycle and held until the next input delivery.
- CioAcq  out  1  one-cycle acknowledge pulse to the core.
- sink_enable  in  SINKS  per-sink participation mask; sampled at the start of a broadcast.
- sink_valid  out  SINKS  per-sink valid.
- sink_data  out  8  broadcast byte.
- sink_ready  in  SINKS  per-sink ready.
- src_valid  in  2  source valid; bit 0 is the keyboard, bit 1 is the host.
- src_data  in  16  source bytes; [7:0] is the keyboard, [15:8] is the host.
- src_ready  out  2  source ready; combinational.
- timeout_clear  in  1  clears sink_timeout.
- sink_timeout  out  SINKS  sticky flag per sink that was dropped on timeout.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current input FIFO occupancy.
- busy  out  1  high whenever the state is not IDLE.

## Operation
- States: IDLE, BCAST, OUT_ACK, IN_ACK, WAIT_LOW.
- IDLE with Cout=1:
  - latch stdout into sink_data;
  - pending ← sink_enable;
  - timer ← 0;
  - go to BCAST.
- Cout has priority over CinReq when both are high.
- IDLE with CinReq=1, Cout=0 and fifo_count>0:
  - stdin ← FIFO head;
  - pop the FIFO;
  - go to IN_ACK.
- IDLE with CinReq=1 and an empty FIFO: stay in IDLE, no acknowledge.
- BCAST:
  - sink_valid = pending.
  - Each sink_valid[i]&sink_ready[i] clears pending[i].
  - When pending becomes 0 (after this cycle's clears), go to OUT_ACK.
  - The timer increments each cycle. When timer reaches TIMEOUT_CYCLES-1 with pending≠0: sink_timeout |= pending, pending ← 0, go to OUT_ACK.
- OUT_ACK and IN_ACK: CioAcq=1 for exactly this cycle, then WAIT_LOW.
- WAIT_LOW: return to IDLE once Cout=0 and CinReq=0. This prevents a held request from being acknowledged twice.
- Input arbitration:
  - The grant goes to the only valid source. If both are valid, it goes to the source indicated by the round-robin pointer.
  - src_ready[g] = grant & ~full.
  - A push happens on src_valid&src_ready, at most one per cycle. After each push the pointer moves to the other source.
  - Arbitration runs in every state, independent of the core handshake.
- FIFO boundary rules:
  - When full, both src_ready are 0.
  - A simultaneous push and pop leaves fifo_count unchanged; the pop returns the old head.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- timeout_clear has priority over a same-cycle timeout set, so the flag ends cleared.

## Timing
- Reset values:
  - state IDLE;
  - CioAcq, sink_valid, busy and sink_timeout all 0;
  - stdin 0 and sink_data 0;
  - FIFO empty, so fifo_count=0;
  - round-robin pointer set to the keyboard;
  - timer 0.
- Reset in any state drops in-flight data without an acknowledge. The FIFO contents are lost.
- Output latency: Cout is sampled high at cycle N, so sink_valid is asserted at N+1.
  - With all sinks ready at N+1, CioAcq pulses at N+2.
  - With sink_enable=0, CioAcq also pulses at N+2.
- Input latency: CinReq is sampled high at cycle N with the FIFO non-empty, so stdin is updated and CioAcq pulses at N+1.
- A push accepted at cycle N is poppable from N+1.
- Timeout: the acknowledge comes TIMEOUT_CYCLES+1 cycles after N.

## Structure
- Package cio_pkg holds:
  - the state enum `cio_state_t`;
  - the source indices SRC_KEYBOARD=0 and SRC_HOST=1;
  - the byte width constant CIO_WIDTH=8.
- Sub-module cio_fifo is a synchronous FIFO with parameter DEPTH and ports push, pop, din, dout, full, empty and count. It has no bypass.
- Arbitration, the state machine and the timer live in cio_scheduler.

## Test plan
- Broadcast: sink_enable=2'b11, both sinks ready, Cout with stdout=8'h41.
  - Expect sink_data=8'h41 and sink_valid=2'b11 for one cycle.
  - Expect CioAcq exactly 2 cycles after Cout is sampled.
- Staggered sinks: sink 0 ready immediately, sink 1 ready after 5 cycles.
  - Expect sink_valid[0] to drop after 1 cycle.
  - Expect CioAcq one cycle after sink 1 accepts.
- Timeout: TIMEOUT_CYCLES=16, sink 1 never ready.
  - Expect sink_timeout=2'b10 and CioAcq.
  - Then pulse timeout_clear and expect sink_timeout=0.
- Round-robin and full: both sources continuously valid with 8'h10 and 8'h20, FIFO_DEPTH=4, no CinReq.
  - Expect pushes in the order 10, 20, 10, 20.
  - Expect src_ready=0 with fifo_count=4.
- Input and priority:
  - Cout and CinReq raised together with a non-empty FIFO: the output is acknowledged first.
  - After WAIT_LOW with CinReq still high: stdin=FIFO head, CioAcq at the next cycle, fifo_count decremented.
  - With CinReq held past CioAcq: no second acknowledge.
- Reset mid-BCAST: expect no CioAcq, sink_valid=0, fifo_count=0 and busy=0 in the next cycle.

Source files
------------

// File: rtl/cio_pkg.sv
// Shared types and constants for the character-I/O scheduler.
package cio_pkg;

  localparam int CIO_WIDTH    = 8;
  localparam int SRC_KEYBOARD = 0;
  localparam int SRC_HOST     = 1;

  typedef enum logic [2:0] {
    IDLE,
    BCAST,
    OUT_ACK,
    IN_ACK,
    WAIT_LOW
  } cio_state_t;

endpackage

// File: rtl/cio_fifo.sv
// Small synchronous FIFO for input characters. dout always shows the head
// entry (no bypass), so a byte pushed in one cycle is poppable the next.
module cio_fifo
  import cio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [CIO_WIDTH-1:0]   din,
  output logic [CIO_WIDTH-1:0]   dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [CIO_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr_reg;
  logic [AW-1:0]        rd_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic                 push_ok;
  logic                 pop_ok;

  assign full    = (count_reg == CW'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  // The array is tiny, so the head is read asynchronously; a push never
  // targets the head slot while the FIFO holds data, so a same-cycle pop
  // always sees the old head.
  assign dout    = mem[rd_ptr_reg];

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/cio_scheduler.sv
// Console handshake scheduler: broadcasts core output to all enabled sinks
// and feeds round-robin-arbitrated keyboard/host bytes to the core.
module cio_scheduler
  import cio_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int SINKS          = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic                        Cout,
  input  logic                        CinReq,
  input  logic [CIO_WIDTH-1:0]        stdout,
  output logic [CIO_WIDTH-1:0]        stdin,
  output logic                        CioAcq,
  input  logic [SINKS-1:0]            sink_enable,
  output logic [SINKS-1:0]            sink_valid,
  output logic [CIO_WIDTH-1:0]        sink_data,
  input  logic [SINKS-1:0]            sink_ready,
  input  logic [1:0]                  src_valid,
  input  logic [2*CIO_WIDTH-1:0]      src_data,
  output logic [1:0]                  src_ready,
  input  logic                        timeout_clear,
  output logic [SINKS-1:0]            sink_timeout,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        busy
);

  cio_state_t           state_reg;
  logic [SINKS-1:0]     pending_reg;
  logic [15:0]          timer_reg;
  logic [CIO_WIDTH-1:0] stdin_reg;
  logic [CIO_WIDTH-1:0] sink_data_reg;
  logic                 cio_acq_reg;
  logic [SINKS-1:0]     sink_timeout_reg;
  logic                 rr_ptr_reg;

  logic                 grant_valid;
  logic                 grant_idx;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CIO_WIDTH-1:0] fifo_din;
  logic [CIO_WIDTH-1:0] fifo_dout;
  logic [SINKS-1:0]     pending_left;
  logic                 timed_out;
  logic [SINKS-1:0]     timeout_set;

  assign stdin        = stdin_reg;
  assign sink_data    = sink_data_reg;
  assign CioAcq       = cio_acq_reg;
  assign sink_timeout = sink_timeout_reg;
  assign busy         = (state_reg != IDLE);
  assign sink_valid   = (state_reg == BCAST) ? pending_reg : '0;

  // Sinks still owing an accept once this cycle's handshakes are counted.
  assign pending_left = pending_reg & ~sink_ready;
  assign timed_out    = (timer_reg == 16'(TIMEOUT_CYCLES - 1));
  assign timeout_set  = (state_reg == BCAST && timed_out) ? pending_left : '0;

  assign fifo_pop = (state_reg == IDLE) & ~Cout & CinReq & ~fifo_empty;

  // Grant the lone valid source, or the round-robin pick when both are valid.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 1'(SRC_KEYBOARD);
    src_ready   = 2'b00;
    case (src_valid)
      2'b01: begin grant_valid = 1'b1; grant_idx = 1'(SRC_KEYBOARD); end
      2'b10: begin grant_valid = 1'b1; grant_idx = 1'(SRC_HOST);     end
      2'b11: begin grant_valid = 1'b1; grant_idx = rr_ptr_reg;       end
      default: ;
    endcase
    if (grant_valid && !fifo_full) src_ready[grant_idx] = 1'b1;
    fifo_push = grant_valid & ~fifo_full;
    fifo_din  = grant_idx ? src_data[2*CIO_WIDTH-1:CIO_WIDTH] : src_data[CIO_WIDTH-1:0];
  end

  // After each push the other source gets preference on the next tie.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      rr_ptr_reg <= 1'(SRC_KEYBOARD);
    end else if (fifo_push) begin
      rr_ptr_reg <= ~grant_idx;
    end
  end

  // Handshake state machine with registered acknowledge, data and flags.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg        <= IDLE;
      pending_reg      <= '0;
      timer_reg        <= '0;
      stdin_reg        <= '0;
      sink_data_reg    <= '0;
      cio_acq_reg      <= 1'b0;
      sink_timeout_reg <= '0;
    end else begin
      cio_acq_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (Cout) begin
            sink_data_reg <= stdout;
            pending_reg   <= sink_enable;
            timer_reg     <= '0;
            state_reg     <= BCAST;
          end else if (fifo_pop) begin
            stdin_reg   <= fifo_dout;
            cio_acq_reg <= 1'b1;
            state_reg   <= IN_ACK;
          end
        end
        BCAST: begin
          pending_reg <= pending_left;
          timer_reg   <= timer_reg + 1'b1;
          if (pending_left == '0) begin
            cio_acq_reg <= 1'b1;
            state_reg   <= OUT_ACK;
          end else if (timed_out) begin
            pending_reg <= '0;
            cio_acq_reg <= 1'b1;
            state_reg   <= OUT_ACK;
          end
        end
        OUT_ACK, IN_ACK: state_reg <= WAIT_LOW;
        WAIT_LOW: begin
          if (!Cout && !CinReq) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
      // A clear wins over a timeout landing in the same cycle.
      if (timeout_clear) sink_timeout_reg <= '0;
      else               sink_timeout_reg <= sink_timeout_reg | timeout_set;
    end
  end

  cio_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (Clk),
    .srst  (Rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (fifo_din),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_cio_scheduler.sv
// Directed bench for cio_scheduler: broadcast, staggered sinks, timeout,
// round-robin fill, input delivery/priority and reset mid-broadcast.
module tb_cio_scheduler;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        Cout;
  logic        CinReq;
  logic [7:0]  stdout;
  logic [7:0]  stdin;
  logic        CioAcq;
  logic [1:0]  sink_enable;
  logic [1:0]  sink_valid;
  logic [7:0]  sink_data;
  logic [1:0]  sink_ready;
  logic [1:0]  src_valid;
  logic [15:0] src_data;
  logic [1:0]  src_ready;
  logic        timeout_clear;
  logic [1:0]  sink_timeout;
  logic [2:0]  fifo_count;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  cio_scheduler #(
    .FIFO_DEPTH(4),
    .SINKS(2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .Cout          (Cout),
    .CinReq        (CinReq),
    .stdout        (stdout),
    .stdin         (stdin),
    .CioAcq        (CioAcq),
    .sink_enable   (sink_enable),
    .sink_valid    (sink_valid),
    .sink_data     (sink_data),
    .sink_ready    (sink_ready),
    .src_valid     (src_valid),
    .src_data      (src_data),
    .src_ready     (src_ready),
    .timeout_clear (timeout_clear),
    .sink_timeout  (sink_timeout),
    .fifo_count    (fifo_count),
    .busy          (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge Clk);
  endtask

  // Drop both requests and wait (bounded) for the scheduler to go idle.
  task automatic go_idle();
    Cout   = 1'b0;
    CinReq = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (!busy) break;
    end
    check("return_idle", 32'(busy), 32'h0);
  endtask

  logic [1:0] exp_ready [5];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; Cout = 1'b0; CinReq = 1'b0; stdout = 8'h00;
    sink_enable = 2'b00; sink_ready = 2'b00; src_valid = 2'b00;
    src_data = 16'h0000; timeout_clear = 1'b0;
    repeat (3) tick();
    Rst = 1'b0;
    tick();

    // Reset state
    check("rst_acq",        32'(CioAcq),       32'h0);
    check("rst_sink_valid", 32'(sink_valid),   32'h0);
    check("rst_busy",       32'(busy),         32'h0);
    check("rst_timeout",    32'(sink_timeout), 32'h0);
    check("rst_stdin",      32'(stdin),        32'h0);
    check("rst_sink_data",  32'(sink_data),    32'h0);
    check("rst_count",      32'(fifo_count),   32'h0);
    $display("tx reset done");

    // Broadcast to two ready sinks
    sink_enable = 2'b11; sink_ready = 2'b11; stdout = 8'h41; Cout = 1'b1;
    tick();
    check("bc_valid", 32'(sink_valid), 32'h3);
    check("bc_data",  32'(sink_data),  32'h41);
    check("bc_acq_early", 32'(CioAcq), 32'h0);
    tick();
    check("bc_acq",       32'(CioAcq),     32'h1);
    check("bc_valid_off", 32'(sink_valid), 32'h0);
    Cout = 1'b0;
    tick();
    check("bc_acq_once", 32'(CioAcq), 32'h0);
    go_idle();
    $display("tx broadcast byte=41");

    // Staggered sinks: sink 1 accepts 5 cycles late
    sink_ready = 2'b01; stdout = 8'h55; Cout = 1'b1;
    tick();
    check("stg_valid0", 32'(sink_valid), 32'h3);
    tick();
    check("stg_valid1", 32'(sink_valid), 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stg_wait_valid", 32'(sink_valid), 32'h2);
      check("stg_wait_acq",   32'(CioAcq),     32'h0);
    end
    sink_ready = 2'b10;
    tick();
    check("stg_acq",     32'(CioAcq),       32'h1);
    check("stg_no_tout", 32'(sink_timeout), 32'h0);
    go_idle();
    $display("tx staggered byte=55");

    // Timeout: sink 1 never ready, ack 17 cycles after Cout is sampled
    sink_ready = 2'b01; stdout = 8'h66; Cout = 1'b1;
    for (int i = 1; i <= 16; i++) tick();
    check("to_acq_early", 32'(CioAcq),     32'h0);
    check("to_pending",   32'(sink_valid), 32'h2);
    tick();
    check("to_acq",  32'(CioAcq),       32'h1);
    check("to_flag", 32'(sink_timeout), 32'h2);
    go_idle();
    check("to_sticky", 32'(sink_timeout), 32'h2);
    timeout_clear = 1'b1;
    tick();
    timeout_clear = 1'b0;
    check("to_clear", 32'(sink_timeout), 32'h0);
    $display("tx timeout byte=66 flag=10");

    // Round-robin fill to full
    sink_ready = 2'b11;
    exp_ready[0] = 2'b01; exp_ready[1] = 2'b10; exp_ready[2] = 2'b01;
    exp_ready[3] = 2'b10; exp_ready[4] = 2'b00;
    src_data = 16'h2010; src_valid = 2'b11;
    #1;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      check("rr_count", 32'(fifo_count), 32'(k));
      check("rr_ready", 32'(src_ready),  32'(exp_ready[k]));
    end
    src_valid = 2'b00;
    $display("tx fifo fill count=4");

    // Cout and CinReq together: output wins
    stdout = 8'h77; Cout = 1'b1; CinReq = 1'b1;
    tick();
    check("pri_bcast", 32'(sink_valid), 32'h3);
    check("pri_count", 32'(fifo_count), 32'h4);
    tick();
    check("pri_acq",   32'(CioAcq),    32'h1);
    check("pri_data",  32'(sink_data), 32'h77);
    check("pri_stdin", 32'(stdin),     32'h0);
    Cout = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("held_no_acq", 32'(CioAcq), 32'h0);
    end
    check("held_busy", 32'(busy), 32'h1);
    CinReq = 1'b0;
    tick();
    check("held_release", 32'(busy), 32'h0);
    $display("tx output-first byte=77");

    // Input delivery, held request gets one ack only
    CinReq = 1'b1;
    tick();
    check("in1_acq",   32'(CioAcq),     32'h1);
    check("in1_stdin", 32'(stdin),      32'h10);
    check("in1_count", 32'(fifo_count), 32'h3);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("in1_once", 32'(CioAcq), 32'h0);
    end
    check("in1_count_hold", 32'(fifo_count), 32'h3);
    go_idle();
    $display("tx input byte=10");

    CinReq = 1'b1;
    tick();
    check("in2_stdin", 32'(stdin),      32'h20);
    check("in2_count", 32'(fifo_count), 32'h2);
    go_idle();
    $display("tx input byte=20");

    // Simultaneous push and pop: count unchanged, old head returned
    src_valid = 2'b01; src_data = 16'h0033; CinReq = 1'b1;
    tick();
    src_valid = 2'b00;
    check("pp_acq",   32'(CioAcq),     32'h1);
    check("pp_stdin", 32'(stdin),      32'h10);
    check("pp_count", 32'(fifo_count), 32'h2);
    go_idle();
    $display("tx push+pop byte=10");

    CinReq = 1'b1;
    tick();
    check("in4_stdin", 32'(stdin), 32'h20);
    go_idle();
    CinReq = 1'b1;
    tick();
    check("in5_stdin", 32'(stdin),      32'h33);
    check("in5_count", 32'(fifo_count), 32'h0);
    go_idle();
    $display("tx drain bytes=20,33");

    // Empty FIFO: request is left waiting
    CinReq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("empty_no_acq", 32'(CioAcq), 32'h0);
    end
    check("empty_idle", 32'(busy), 32'h0);
    CinReq = 1'b0;
    tick();
    $display("tx empty request held");

    // Reset mid-broadcast drops everything
    sink_ready = 2'b00; stdout = 8'h99; Cout = 1'b1;
    src_valid = 2'b01; src_data = 16'h0044;
    tick();
    src_valid = 2'b00;
    check("mr_busy",  32'(busy),       32'h1);
    check("mr_count", 32'(fifo_count), 32'h1);
    Rst = 1'b1;
    tick();
    check("mr_acq",   32'(CioAcq),     32'h0);
    check("mr_valid", 32'(sink_valid), 32'h0);
    check("mr_fifo",  32'(fifo_count), 32'h0);
    check("mr_idle",  32'(busy),       32'h0);
    Rst = 1'b0; Cout = 1'b0;
    tick();
    check("mr_no_acq_after", 32'(CioAcq), 32'h0);
    $display("tx reset mid-broadcast");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
